// File: rtl/cache_pkg.sv
// Shared types and constants for the split L1 and its next-level refill arbiter.
package cache_pkg;

    localparam int unsigned LINE_W   = 64;
    localparam int unsigned OFFSET_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_e;

    // Values double as bit indices into the {d, i} request/grant vectors.
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker. The prio flop names the side that wins a tie
// and flips to the other side whenever a grant is taken under update.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);
    import cache_pkg::*;

    owner_e prio_q, prio_d;

    // Grant decode: a lone requester wins, a tie goes to prio.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (prio_q == OWN_D) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // Priority moves to the loser of each accepted grant.
    always_comb begin
        prio_d = prio_q;
        if (update && (gnt != 2'b00)) begin
            prio_d = gnt[1] ? OWN_I : OWN_D;
        end
    end

    // Priority register; data side is favoured out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= OWN_D;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/l1_refill_arbiter.sv
// Shares the next-level memory port between the L1 instruction and data sides.
// One transaction at a time: IDLE picks a winner, ISSUE holds mem_req until ack
// or watchdog expiry, RESP pulses the owner's done with the captured line.
module l1_refill_arbiter #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned LINE_W  = cache_pkg::LINE_W,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_done,
    output logic [LINE_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              busy,
    output logic              err
);
    import cache_pkg::*;

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic [1:0] gnt;
    logic       arb_update;

    // Requests are only looked at in IDLE, so prio advances only on real grants.
    assign arb_update = (state_q == IDLE);

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst    (rst),
        .req    ({d_req, i_req}),
        .update (arb_update),
        .gnt    (gnt)
    );

    // Next-state: latch the winner in IDLE, run the ack watchdog in ISSUE.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        line_d  = line_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (gnt[1]) begin
                    owner_d = OWN_D;
                    addr_d  = {d_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                    we_d    = d_we;
                    wdata_d = d_wdata;
                    state_d = ISSUE;
                end else if (gnt[0]) begin
                    owner_d = OWN_I;
                    addr_d  = {i_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                    we_d    = 1'b0;
                    wdata_d = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_ack) begin
                    // Writes return no data; keep the requester's view clean.
                    line_d  = we_q ? '0 : mem_rdata;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        line_d  = '0;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched-transaction registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_I;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            line_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            line_q  <= line_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode from registered state only; data buses are zero when not in use.
    always_comb begin
        mem_req   = (state_q == ISSUE);
        mem_we    = mem_req & we_q;
        mem_addr  = mem_req ? addr_q : '0;
        mem_wdata = mem_req ? wdata_q : '0;
        i_done    = (state_q == RESP) && (owner_q == OWN_I);
        d_done    = (state_q == RESP) && (owner_q == OWN_D);
        i_rdata   = i_done ? line_q : '0;
        d_rdata   = d_done ? line_q : '0;
        busy      = (state_q != IDLE);
        err       = err_q;
    end

endmodule

// File: tb/tb_l1_refill_arbiter.sv
// Directed bench for l1_refill_arbiter: a per-cycle vector table plus a short
// hand-driven transaction with a bounded wait on mem_req.
module tb_l1_refill_arbiter;

    localparam logic [15:0] IA  = 16'h0123;
    localparam logic [15:0] IAL = 16'h0120;
    localparam logic [15:0] DA  = 16'h0208;
    localparam logic [15:0] DB  = 16'h0310;
    localparam logic [63:0] DW  = 64'hA5A5_A5A5_5A5A_5A5A;
    localparam logic [63:0] LI  = 64'hDEAD_BEEF_0011_2233;
    localparam logic [63:0] L1  = 64'h1111_2222_3333_4444;
    localparam logic [63:0] L2  = 64'h5555_6666_7777_8888;
    localparam logic [63:0] L3  = 64'h9999_AAAA_BBBB_CCCC;
    localparam logic [63:0] L4  = 64'h0F0F_F0F0_1234_5678;
    localparam logic [63:0] L5  = 64'hCAFE_F00D_8765_4321;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_done, d_req, d_we, d_done;
    logic [15:0] i_addr, d_addr, mem_addr;
    logic [63:0] i_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;
    logic        mem_req, mem_we, mem_ack, busy, err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    l1_refill_arbiter #(
        .ADDR_W  (16),
        .LINE_W  (64),
        .TIMEOUT (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_done    (i_done),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .err       (err)
    );

    typedef struct {
        logic        rst, ir;
        logic [15:0] ia;
        logic        dr, dwe;
        logic [15:0] da;
        logic [63:0] dwd;
        logic        ack;
        logic [63:0] rd;
    } stim_t;

    typedef struct {
        logic        mreq, mwe;
        logic [15:0] maddr;
        logic [63:0] mwd;
        logic        idn;
        logic [63:0] ird;
        logic        ddn;
        logic [63:0] drd;
        logic        bsy, er;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    vec_t tbl[$];

    function automatic stim_t fi(input logic r, input logic ir, input logic [15:0] ia,
                                 input logic dr, input logic dwe, input logic [15:0] da,
                                 input logic [63:0] dwd, input logic ack,
                                 input logic [63:0] rd);
        stim_t s;
        s.rst = r; s.ir = ir; s.ia = ia; s.dr = dr; s.dwe = dwe;
        s.da = da; s.dwd = dwd; s.ack = ack; s.rd = rd;
        return s;
    endfunction

    function automatic exp_t fe(input logic mreq, input logic mwe, input logic [15:0] maddr,
                                input logic [63:0] mwd, input logic idn,
                                input logic [63:0] ird, input logic ddn,
                                input logic [63:0] drd, input logic bsy, input logic er);
        exp_t e;
        e.mreq = mreq; e.mwe = mwe; e.maddr = maddr; e.mwd = mwd; e.idn = idn;
        e.ird = ird; e.ddn = ddn; e.drd = drd; e.bsy = bsy; e.er = er;
        return e;
    endfunction

    task automatic add(input stim_t s, input exp_t e);
        vec_t v;
        v.s = s;
        v.e = e;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input stim_t s);
        rst = s.rst; i_req = s.ir; i_addr = s.ia; d_req = s.dr; d_we = s.dwe;
        d_addr = s.da; d_wdata = s.dwd; mem_ack = s.ack; mem_rdata = s.rd;
    endtask

    function automatic logic [255:0] pack_exp(input exp_t e);
        return 256'({e.mreq, e.mwe, e.maddr, e.mwd, e.idn, e.ird, e.ddn, e.drd, e.bsy, e.er});
    endfunction

    function automatic logic [255:0] pack_act();
        return 256'({mem_req, mem_we, mem_addr, mem_wdata, i_done, i_rdata, d_done, d_rdata,
                     busy, err});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        exp_t z;
        int   n;
        z = fe(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Single I refill, alignment, done carries the acked line.
        add(fi(0, 1, IA, 0, 0, 0, 0, 0, 0),     z);
        add(fi(0, 1, IA, 0, 0, 0, 0, 1, LI),    fe(1, 0, IAL, 0, 0, 0, 0, 0, 1, 0));
        add(fi(0, 1, IA, 0, 0, 0, 0, 0, 0),     fe(0, 0, 0, 0, 1, LI, 0, 0, 1, 0));
        add(fi(0, 0, 0, 0, 0, 0, 0, 0, 0),      z);
        // D write, ack on the fourth ISSUE cycle; input changes after latch are ignored.
        add(fi(0, 0, 0, 1, 1, DA, DW, 0, 0),    z);
        add(fi(0, 0, 0, 1, 1, DA, DW, 0, 0),    fe(1, 1, DA, DW, 0, 0, 0, 0, 1, 0));
        add(fi(0, 0, 0, 1, 1, 0, 0, 0, 0),      fe(1, 1, DA, DW, 0, 0, 0, 0, 1, 0));
        add(fi(0, 0, 0, 1, 0, 16'hFFF8, 1, 0, 0), fe(1, 1, DA, DW, 0, 0, 0, 0, 1, 0));
        add(fi(0, 0, 0, 1, 1, DA, DW, 1, ONES), fe(1, 1, DA, DW, 0, 0, 0, 0, 1, 0));
        add(fi(0, 0, 0, 1, 1, DA, DW, 0, 0),    fe(0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        // Spurious ack in IDLE.
        add(fi(0, 0, 0, 0, 0, 0, 0, 0, 0),      z);
        add(fi(0, 0, 0, 0, 0, 0, 0, 1, L1),     z);
        add(fi(0, 0, 0, 0, 0, 0, 0, 0, 0),      z);
        // Reset, then continuous contention: D, I, D, I.
        add(fi(1, 1, IA, 1, 0, DB, 0, 0, 0),    z);
        add(fi(0, 1, IA, 1, 0, DB, 0, 0, 0),    z);
        add(fi(0, 1, IA, 1, 0, DB, 0, 1, L1),   fe(1, 0, DB, 0, 0, 0, 0, 0, 1, 0));
        add(fi(0, 1, IA, 1, 0, DB, 0, 0, 0),    fe(0, 0, 0, 0, 0, 0, 1, L1, 1, 0));
        add(fi(0, 1, IA, 1, 0, DB, 0, 0, 0),    z);
        add(fi(0, 1, IA, 1, 0, DB, 0, 1, L2),   fe(1, 0, IAL, 0, 0, 0, 0, 0, 1, 0));
        add(fi(0, 1, IA, 1, 0, DB, 0, 0, 0),    fe(0, 0, 0, 0, 1, L2, 0, 0, 1, 0));
        add(fi(0, 1, IA, 1, 0, DB, 0, 0, 0),    z);
        add(fi(0, 1, IA, 1, 0, DB, 0, 1, L3),   fe(1, 0, DB, 0, 0, 0, 0, 0, 1, 0));
        add(fi(0, 1, IA, 1, 0, DB, 0, 0, 0),    fe(0, 0, 0, 0, 0, 0, 1, L3, 1, 0));
        add(fi(0, 1, IA, 1, 0, DB, 0, 0, 0),    z);
        add(fi(0, 1, IA, 1, 0, DB, 0, 1, L4),   fe(1, 0, IAL, 0, 0, 0, 0, 0, 1, 0));
        add(fi(0, 1, IA, 1, 0, DB, 0, 0, 0),    fe(0, 0, 0, 0, 1, L4, 0, 0, 1, 0));
        add(fi(0, 0, 0, 0, 0, 0, 0, 0, 0),      z);
        // Reset mid-ISSUE: transaction dropped, prio back to D.
        add(fi(0, 0, 0, 1, 0, DB, 0, 0, 0),     z);
        add(fi(1, 0, 0, 1, 0, DB, 0, 0, 0),     fe(1, 0, DB, 0, 0, 0, 0, 0, 1, 0));
        add(fi(0, 1, IA, 1, 0, DB, 0, 0, 0),    z);
        add(fi(0, 1, IA, 1, 0, DB, 0, 1, L5),   fe(1, 0, DB, 0, 0, 0, 0, 0, 1, 0));
        add(fi(0, 1, IA, 0, 0, 0, 0, 0, 0),     fe(0, 0, 0, 0, 0, 0, 1, L5, 1, 0));
        add(fi(0, 1, IA, 0, 0, 0, 0, 0, 0),     z);
        add(fi(0, 1, IA, 0, 0, 0, 0, 1, LI),    fe(1, 0, IAL, 0, 0, 0, 0, 0, 1, 0));
        add(fi(0, 1, IA, 0, 0, 0, 0, 0, 0),     fe(0, 0, 0, 0, 1, LI, 0, 0, 1, 0));
        add(fi(0, 0, 0, 0, 0, 0, 0, 0, 0),      z);
        // Timeout after 4 unacked cycles; err sticks through a later I refill.
        add(fi(0, 0, 0, 1, 0, DA, 0, 0, 0),     z);
        for (int k = 0; k < 4; k++) begin
            add(fi(0, 0, 0, 1, 0, DA, 0, 0, 0), fe(1, 0, DA, 0, 0, 0, 0, 0, 1, 0));
        end
        add(fi(0, 0, 0, 1, 0, DA, 0, 0, 0),     fe(0, 0, 0, 0, 0, 0, 1, 0, 1, 1));
        add(fi(0, 1, IA, 0, 0, 0, 0, 0, 0),     fe(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        add(fi(0, 1, IA, 0, 0, 0, 0, 1, LI),    fe(1, 0, IAL, 0, 0, 0, 0, 0, 1, 1));
        add(fi(0, 1, IA, 0, 0, 0, 0, 0, 0),     fe(0, 0, 0, 0, 1, LI, 0, 0, 1, 1));
        add(fi(0, 0, 0, 0, 0, 0, 0, 0, 0),      fe(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

        drive(fi(1, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);

        foreach (tbl[k]) begin
            @(negedge clk);
            chk($sformatf("row%0d", k), pack_act(), pack_exp(tbl[k].e));
            drive(tbl[k].s);
        end

        // Hand-driven D refill with a bounded wait for mem_req and a late ack.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0457;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_req && n < 8);
        chk("hs_mem_req", 256'(mem_req), 256'(1));
        chk("hs_mem_addr", 256'(mem_addr), 256'(16'h0450));
        @(negedge clk);
        chk("hs_still_waiting", 256'({mem_req, d_done}), 256'(2'b10));
        mem_ack = 1'b1; mem_rdata = L3;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = '0;
        chk("hs_done", 256'({d_done, i_done, d_rdata}), 256'({1'b1, 1'b0, L3}));
        d_req = 1'b0;
        @(negedge clk);
        chk("hs_pulse_end", 256'({d_done, busy, err}), 256'(3'b001));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
